// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Instruction-memory port owner. Sequences a loader phase, then PC
//            generation with stall, branch redirect, EBREAK halt and errors.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  input  logic        reload,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_A,
  output logic        imem_we,
  output logic [31:0] imem_WD,
  input  logic [31:0] imem_RD,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F,
  output logic [31:0] Instr_F,
  output logic        f_valid,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [10:0] load_count,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [32:0] ADDR_LIMIT      = 33'(DEPTH) * 33'd4;
  localparam logic [31:0] EBREAK          = 32'h0010_0073;
  localparam logic [10:0] LOAD_CNT_MAX    = 11'h7FF;
  localparam logic [1:0]  ERR_NONE        = 2'b00;
  localparam logic [1:0]  ERR_LOAD_ADDR   = 2'b01;
  localparam logic [1:0]  ERR_FETCH_RANGE = 2'b10;
  localparam logic [1:0]  ERR_BR_ALIGN    = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  err_q, err_d;
  logic [10:0] load_count_q, load_count_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic ld_addr_ok;
  logic pc_in_range;
  logic in_load;
  logic in_run;

  assign ld_addr_ok  = (ld_addr[1:0] == 2'b00) && ({1'b0, ld_addr} < ADDR_LIMIT);
  assign pc_in_range = ({1'b0, pc_q} < ADDR_LIMIT);
  assign in_load     = (state_q == ST_LOAD);
  assign in_run      = (state_q == ST_RUN);

  // Handshake and write enable depend on state only, never on ld_valid for ready.
  assign ld_ready    = in_load & ~rst;
  assign imem_we     = in_load & ld_valid & ld_addr_ok & ~rst;
  assign imem_A      = in_load ? ld_addr : pc_q;
  assign imem_WD     = ld_data;
  assign f_valid     = in_run & pc_in_range & ~rst;
  assign Instr_F     = in_load ? 32'h0 : imem_RD;
  assign PC_F        = pc_q;
  assign PCPlus4_F   = pc_q + 32'd4;
  assign halted      = (state_q == ST_HALT);
  assign err_code    = err_q;
  assign load_count  = load_count_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    err_d         = err_q;
    load_count_d  = load_count_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_valid) begin
          if (ld_addr_ok) begin
            if (load_count_q != LOAD_CNT_MAX) begin
              load_count_d = load_count_q + 11'd1;
            end
          end else if (err_q == ERR_NONE) begin
            err_d = ERR_LOAD_ADDR;
          end
        end
        if (ld_done) begin
          state_d       = ST_RUN;
          pc_d          = RESET_PC;
          fetch_count_d = 32'h0;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d      = ST_LOAD;
          err_d        = ERR_NONE;
          load_count_d = 11'h0;
        end else if (!pc_in_range) begin
          state_d = ST_HALT;
          if (err_q == ERR_NONE) err_d = ERR_FETCH_RANGE;
        end else if (br_taken) begin
          if (br_target[1:0] != 2'b00) begin
            state_d = ST_HALT;
            if (err_q == ERR_NONE) err_d = ERR_BR_ALIGN;
          end else begin
            pc_d = br_target;
          end
        end else if (!stall) begin
          fetch_count_d = fetch_count_q + 32'd1;
          // EBREAK is counted as a fetch but leaves the PC on itself.
          if (imem_RD == EBREAK) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_HALT: begin
        if (reload) begin
          state_d      = ST_LOAD;
          err_d        = ERR_NONE;
          load_count_d = 11'h0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      pc_q          <= RESET_PC;
      err_q         <= ERR_NONE;
      load_count_q  <= 11'h0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      err_q         <= err_d;
      load_count_q  <= load_count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and port owner for the single-port instruction memory. After reset it runs a LOAD phase in which an external loader writes program words into the memory through a valid/ready port. On `ld_done` it switches to RUN and generates the program counter and fetch address every cycle, handling stall, branch redirect, halt-on-EBREAK and address-error detection. It sits between the instruction memory and the core's decode stage and is the only block that drives the memory address.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on entry to RUN; must be word aligned
- `DEPTH`, 1024, memory size in 32-bit words; the legal byte range is 0 .. DEPTH*4-4
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ld_valid`  in  1  loader word valid
- `ld_ready`  out  1  loader word accepted this cycle when high together with `ld_valid`
- `ld_addr`  in  32  loader byte address
- `ld_data`  in  32  loader instruction word
- `ld_done`  in  1  loader finished; LOAD -> RUN
- `reload`  in  1  from RUN or HALT, return to LOAD
- `stall`  in  1  hold PC (decode not ready)
- `br_taken`  in  1  redirect request
- `br_target`  in  32  redirect byte address
- `imem_A`  out  32  memory byte address
- `imem_we`  out  1  memory write enable
- `imem_WD`  out  32  memory write data
- `imem_RD`  in  32  memory read data (combinational read)
- `PC_F`  out  32  current fetch PC
- `PCPlus4_F`  out  32  `PC_F` + 4, mod 2^32
- `Instr_F`  out  32  fetched instruction
- `f_valid`  out  1  `Instr_F` valid for decode
- `halted`  out  1  state == HALT
- `err_code`  out  2  sticky first error: 00 none, 01 bad loader address, 10 fetch out of range, 11 misaligned branch target
- `load_count`  out  11  words written in the current LOAD phase (saturates at 2047)
- `fetch_count`  out  32  advancing fetches since RUN entry (wraps)

## Operation
- States: LOAD, RUN, HALT. Reset forces LOAD.
- Reset values:
  - `PC_F`=RESET_PC, `err_code`=0, both counters 0.
  - While `rst` is high: `ld_ready`=0, `imem_we`=0, `f_valid`=0.
- LOAD:
  - `ld_ready`=1. `imem_A`=`ld_addr`, `imem_WD`=`ld_data`.
  - `imem_we` = `ld_valid` & address aligned (`ld_addr[1:0]`==0) & `ld_addr` < DEPTH*4.
  - A handshaked word with a bad address is consumed and not written; it sets `err_code`=01 if `err_code` is 00.
  - `load_count` increments on each good write.
  - `f_valid`=0. `Instr_F`=0.
- LOAD exit: `ld_done` -> RUN next cycle, with `PC_F`<=RESET_PC and `fetch_count`<=0. If `ld_valid` and `ld_done` are high in the same cycle, the word is written and the transition still occurs.
- RUN:
  - `ld_ready`=0, `imem_we`=0. `imem_A`=`PC_F`, `Instr_F`=`imem_RD`.
  - `f_valid`=1 unless `PC_F` >= DEPTH*4. An out-of-range PC gives `f_valid`=0, sets `err_code`=10 and goes to HALT next cycle.
- PC update priority in RUN:
  1. `br_taken`: if `br_target[1:0]`!=0, set `err_code`=11, go to HALT and hold PC; else `PC_F`<=`br_target`.
  2. Else `stall`: hold.
  3. Else `PC_F`<=`PC_F`+4, wrapping 32'hFFFF_FFFC -> 0.
- `fetch_count` increments when `f_valid` & !`stall` & !`br_taken`.
- EBREAK: `Instr_F`==32'h0010_0073 with `f_valid` & !`stall` & !`br_taken` -> HALT next cycle, PC held at the EBREAK address.
- HALT: `f_valid`=0, `imem_A`=`PC_F`, nothing updates. Exit only via `rst` or `reload`.
- `reload` in RUN or HALT -> LOAD next cycle; clears `err_code` and `load_count`. It has priority over branch, stall and EBREAK in the same cycle.
- Error codes are sticky: only the first error is recorded. They are cleared by `rst` or `reload`.

## Timing
- Memory read is combinational: `Instr_F` reflects `PC_F` in the same cycle, with zero-cycle fetch latency.
- Redirect: `br_taken` in cycle N -> `PC_F`=`br_target` in cycle N+1. The core owns discarding the wrong-path instruction.
- Loader throughput: one word per cycle. `ld_ready` is a function of state only, so there is no combinational path from `ld_valid`.
- `ld_done` at cycle N -> first valid fetch (`f_valid`=1) at cycle N+1.
- `rst` asserted in any state, mid-load or mid-run, takes effect at the next edge; no write is issued in the reset cycle.

## Test plan
- Load then run: load 4 words at 0,4,8,12 (12 = 32'h0010_0073) and pulse `ld_done`. Expect `load_count`=4 and `PC_F` sequence 0,4,8,12. `halted`=1 from the cycle after PC=12, with `fetch_count`=4.
- Stall/branch priority: in RUN at PC=8, hold `stall` for 3 cycles -> PC stays 8. Assert `stall` and `br_taken` with `br_target`=32'h40 together -> PC=32'h40 next cycle.
- Bad loader addresses: `ld_addr`=32'h6 -> no write, `err_code`=01. A following `ld_addr`=32'h1000 (DEPTH=1024) -> no write, `err_code` stays 01.
- Misaligned branch: `br_target`=32'h22 -> `err_code`=11, HALT, `PC_F` unchanged.
- Out-of-range fetch: RESET_PC=32'hFFC with no branch. PC reaches 32'h1000 -> `f_valid`=0, `err_code`=10, HALT.
- Reset and reload mid-operation:
  - `reload` in HALT -> LOAD with `err_code`=0 and `load_count`=0.
  - `rst` during a loader burst -> `imem_we`=0 in the reset cycle, then LOAD with `ld_ready`=1.
  - Simultaneous `ld_valid` and `ld_done` -> word written, RUN entered next cycle.
